cache_mem_arbiter: RTL and testbench

Shares the single cache-to-memory port between two cache clients (instruction cache = client 0, data cache = client 1) at whole-line granularity. A client that wins arbitration owns the port for one full line transaction: exactly BEATS word requests forwarded to memory and BEATS word responses routed back. Ownership is then released, and the next grant is decided round-robin. The block sits between the caches' batch send/receive units and the test memory, and passes message payloads through unmodified.

---
 rtl/cache_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - line-granular round-robin arbiter sharing one memory port between icache and dcache
module cache_mem_arbiter #(
    parameter int BEATS  = 4,
    parameter int REQ_W  = 77,
    parameter int RESP_W = 47
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c0_req_val,
    output logic              c0_req_rdy,
    input  logic [REQ_W-1:0]  c0_req_msg,
    output logic              c0_resp_val,
    input  logic              c0_resp_rdy,
    output logic [RESP_W-1:0] c0_resp_msg,

    input  logic              c1_req_val,
    output logic              c1_req_rdy,
    input  logic [REQ_W-1:0]  c1_req_msg,
    output logic              c1_resp_val,
    input  logic              c1_resp_rdy,
    output logic [RESP_W-1:0] c1_resp_msg,

    output logic              mem_req_val,
    input  logic              mem_req_rdy,
    output logic [REQ_W-1:0]  mem_req_msg,
    input  logic              mem_resp_val,
    output logic              mem_resp_rdy,
    input  logic [RESP_W-1:0] mem_resp_msg,

    output logic              busy,
    output logic              owner
);

    localparam int CW = $clog2(BEATS + 1);
    localparam logic [CW-1:0] LAST = CW'(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state, state_n;
    logic          owner_n;
    logic          prio, prio_n;
    logic [CW-1:0] req_cnt, req_cnt_n;
    logic [CW-1:0] resp_cnt, resp_cnt_n;
    logic [CW-1:0] req_inc, resp_inc;
    logic          own_req_val, own_resp_rdy;
    logic          req_open, resp_open;
    logic          req_hs, resp_hs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            prio     <= 1'b0;
            req_cnt  <= '0;
            resp_cnt <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            prio     <= prio_n;
            req_cnt  <= req_cnt_n;
            resp_cnt <= resp_cnt_n;
        end
    end

    always_comb begin
        own_req_val  = owner ? c1_req_val  : c0_req_val;
        own_resp_rdy = owner ? c1_resp_rdy : c0_resp_rdy;

        // requests flow only in XFER and stop once the line's beats are sent
        req_open  = (state == XFER) && (req_cnt < LAST);
        resp_open = (state != IDLE);

        mem_req_val  = own_req_val && req_open;
        mem_req_msg  = owner ? c1_req_msg : c0_req_msg;
        c0_req_rdy   = mem_req_rdy && req_open && !owner;
        c1_req_rdy   = mem_req_rdy && req_open &&  owner;

        mem_resp_rdy = resp_open && own_resp_rdy;
        c0_resp_val  = resp_open && mem_resp_val && !owner;
        c1_resp_val  = resp_open && mem_resp_val &&  owner;
        c0_resp_msg  = mem_resp_msg;
        c1_resp_msg  = mem_resp_msg;

        req_hs   = mem_req_val && mem_req_rdy;
        resp_hs  = mem_resp_val && mem_resp_rdy;
        req_inc  = req_cnt + CW'(req_hs);
        resp_inc = resp_cnt + CW'(resp_hs);

        busy = (state != IDLE);
    end

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        prio_n     = prio;
        req_cnt_n  = req_cnt;
        resp_cnt_n = resp_cnt;
        case (state)
            IDLE: begin
                if (c0_req_val || c1_req_val) begin
                    owner_n    = (c0_req_val && c1_req_val) ? prio : c1_req_val;
                    req_cnt_n  = '0;
                    resp_cnt_n = '0;
                    state_n    = XFER;
                end
            end
            XFER: begin
                req_cnt_n  = req_inc;
                resp_cnt_n = resp_inc;
                if (req_inc == LAST) begin
                    if (resp_inc == LAST) begin
                        state_n = IDLE;
                        prio_n  = ~owner;
                    end else begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                resp_cnt_n = resp_inc;
                if (resp_inc == LAST) begin
                    state_n = IDLE;
                    prio_n  = ~owner;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - randomized self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    localparam int BEATS  = 4;
    localparam int REQ_W  = 77;
    localparam int RESP_W = 47;

    typedef logic [REQ_W-1:0]  req_t;
    typedef logic [RESP_W-1:0] resp_t;

    logic clk = 1'b0;
    logic reset;
    logic c0_req_val, c0_req_rdy, c0_resp_val, c0_resp_rdy;
    logic c1_req_val, c1_req_rdy, c1_resp_val, c1_resp_rdy;
    req_t c0_req_msg, c1_req_msg, mem_req_msg;
    resp_t c0_resp_msg, c1_resp_msg, mem_resp_msg;
    logic mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    logic busy, owner;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.BEATS(BEATS), .REQ_W(REQ_W), .RESP_W(RESP_W)) dut (
        .clk(clk), .reset(reset),
        .c0_req_val(c0_req_val), .c0_req_rdy(c0_req_rdy), .c0_req_msg(c0_req_msg),
        .c0_resp_val(c0_resp_val), .c0_resp_rdy(c0_resp_rdy), .c0_resp_msg(c0_resp_msg),
        .c1_req_val(c1_req_val), .c1_req_rdy(c1_req_rdy), .c1_req_msg(c1_req_msg),
        .c1_resp_val(c1_resp_val), .c1_resp_rdy(c1_resp_rdy), .c1_resp_msg(c1_resp_msg),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
        .busy(busy), .owner(owner)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // client line queues and the memory's accepted-request queue
    req_t cq0[$];
    req_t cq1[$];
    req_t mq[$];
    int   mt[$];

    // transaction-level model: who holds the port and how many beats remain
    bit m_busy = 0, m_owner = 0, m_prio = 0;
    int m_req_left = 0, m_resp_left = 0;

    bit rst = 0, en0 = 1, en1 = 1;
    int lat = 1, req_pct = 100, resp_pct = 100, cyc = 0;
    int busy_cnt = 0;
    bit prev_busy = 0;
    int gq[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic resp_t resp_of(input req_t m);
        return m[RESP_W-1:0] ^ resp_t'(64'h1234_5678_9abc);
    endfunction

    task automatic push_line(input int c, input logic [31:0] base, input bit rnd);
        req_t m;
        for (int i = 0; i < BEATS; i++) begin
            if (rnd) m = req_t'({$urandom(), $urandom(), $urandom()});
            else     m = {3'd0, 8'(i), base + 32'(4 * i), 2'd2, 32'(i)};
            if (c == 0) cq0.push_back(m);
            else        cq1.push_back(m);
        end
    endtask

    task automatic tick();
        bit own_val, own_rrdy, e_req_val, e_req_rdy, e_resp_val, e_mresp_rdy, req_hs, resp_hs;
        req_t own_msg;
        reset       = rst;
        c0_req_val  = en0 && (cq0.size() > 0);
        c0_req_msg  = (cq0.size() > 0) ? cq0[0] : '0;
        c1_req_val  = en1 && (cq1.size() > 0);
        c1_req_msg  = (cq1.size() > 0) ? cq1[0] : '0;
        mem_req_rdy = ($urandom_range(99) < req_pct);
        c0_resp_rdy = ($urandom_range(99) < resp_pct);
        c1_resp_rdy = ($urandom_range(99) < resp_pct);

        own_val   = m_owner ? c1_req_val : c0_req_val;
        own_msg   = m_owner ? c1_req_msg : c0_req_msg;
        e_req_val = m_busy && (m_req_left > 0) && own_val;
        e_req_rdy = m_busy && (m_req_left > 0) && mem_req_rdy;
        req_hs    = e_req_val && mem_req_rdy;
        if (req_hs) begin
            mq.push_back(own_msg);
            mt.push_back(cyc);
        end
        mem_resp_val = (mq.size() > 0) && (mt[0] + lat <= cyc);
        mem_resp_msg = (mq.size() > 0) ? resp_of(mq[0]) : '0;
        own_rrdy     = m_owner ? c1_resp_rdy : c0_resp_rdy;
        e_resp_val   = m_busy && mem_resp_val;
        e_mresp_rdy  = m_busy && own_rrdy;
        resp_hs      = e_resp_val && own_rrdy;

        @(negedge clk);
        check("busy", busy, m_busy);
        check("owner", owner, m_owner);
        check("c0_req_rdy", c0_req_rdy, e_req_rdy && !m_owner);
        check("c1_req_rdy", c1_req_rdy, e_req_rdy && m_owner);
        check("mem_req_val", mem_req_val, e_req_val);
        if (e_req_val) check("mem_req_msg", mem_req_msg, own_msg);
        check("c0_resp_val", c0_resp_val, e_resp_val && !m_owner);
        check("c1_resp_val", c1_resp_val, e_resp_val && m_owner);
        check("mem_resp_rdy", mem_resp_rdy, e_mresp_rdy);
        if (e_resp_val) check("resp_msg", m_owner ? c1_resp_msg : c0_resp_msg, mem_resp_msg);
        if (busy === 1'b1) busy_cnt++;
        if (busy === 1'b1 && !prev_busy) gq.push_back(int'(owner));
        prev_busy = (busy === 1'b1);

        @(posedge clk);
        #1;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_prio = 0;
            cq0.delete(); cq1.delete(); mq.delete(); mt.delete();
        end else if (!m_busy) begin
            if (c0_req_val || c1_req_val) begin
                m_owner     = (c0_req_val && c1_req_val) ? m_prio : c1_req_val;
                m_busy      = 1;
                m_req_left  = BEATS;
                m_resp_left = BEATS;
            end
        end else begin
            if (req_hs) begin
                if (m_owner) void'(cq1.pop_front());
                else         void'(cq0.pop_front());
                m_req_left--;
            end
            if (resp_hs) begin
                void'(mq.pop_front());
                void'(mt.pop_front());
                m_resp_left--;
            end
            if (m_req_left == 0 && m_resp_left == 0) begin
                m_busy = 0;
                m_prio = !m_owner;
            end
        end
        cyc++;
    endtask

    task automatic run_until_idle(input int limit);
        int n = 0;
        while ((m_busy || cq0.size() > 0 || cq1.size() > 0) && n < limit) begin
            tick();
            n++;
        end
        check("drain_bound", (n < limit), 1);
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        int exp_grants[4] = '{0, 1, 0, 1};
        int n;
        reset = 1'b1;
        c0_req_val = 0; c1_req_val = 0; c0_req_msg = '0; c1_req_msg = '0;
        c0_resp_rdy = 0; c1_resp_rdy = 0;
        mem_req_rdy = 0; mem_resp_val = 0; mem_resp_msg = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // single line from c0, 1-cycle memory, no backpressure
        busy_cnt = 0;
        push_line(0, 32'h1000, 0);
        run_until_idle(50);
        check("occupancy", busy_cnt, BEATS + 1);

        // two lines per client, all contending: round-robin from c0
        do_reset();
        gq.delete();
        push_line(0, 32'h2000, 0); push_line(0, 32'h2010, 0);
        push_line(1, 32'h3000, 0); push_line(1, 32'h3010, 0);
        run_until_idle(100);
        check("grant_count", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) check("grant_order", gq[i], exp_grants[i]);

        // 50% backpressure both ways; second line waits while first drains
        req_pct = 50; resp_pct = 50;
        push_line(0, 32'h4000, 1); push_line(0, 32'h4010, 1);
        run_until_idle(300);
        req_pct = 100; resp_pct = 100;

        // same-cycle memory response
        lat = 0;
        push_line(0, 32'h5000, 0); push_line(1, 32'h6000, 0);
        run_until_idle(100);

        // reset after two of four requests with a slow memory
        lat = 2;
        push_line(0, 32'h7000, 0);
        n = 0;
        while (!(m_busy && m_req_left == 2) && n < 20) begin
            tick();
            n++;
        end
        check("midline_bound", (n < 20), 1);
        do_reset();
        push_line(1, 32'h8000, 0);
        run_until_idle(50);

        // randomized traffic
        req_pct = 70; resp_pct = 70;
        for (int seg = 0; seg < 4; seg++) begin
            lat = $urandom_range(3);
            for (int k = 0; k < 100; k++) begin
                en0 = ($urandom_range(99) < 85);
                en1 = ($urandom_range(99) < 85);
                if (cq0.size() < 2 * BEATS && $urandom_range(99) < 15) push_line(0, $urandom(), 1);
                if (cq1.size() < 2 * BEATS && $urandom_range(99) < 15) push_line(1, $urandom(), 1);
                tick();
            end
        end
        en0 = 1; en1 = 1;
        run_until_idle(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
